mac_acc: RTL and testbench
==========================

MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator and result width, ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter LEN_W, default 10, width of the term-count field.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a dot-product job, sampled only in IDLE.
REQ-007 SHALL have port len  input  LEN_W  number of terms for the job, sampled with start.
REQ-008 SHALL have port signed_mode  input  1  1 = operands and accumulator are two's complement, sampled with start.
REQ-009 SHALL have port in_valid  input  1  operand pair a/b is valid.
REQ-010 SHALL have port in_ready  output  1  block accepts a pair; a beat is in_valid & in_ready.
REQ-011 SHALL have ports a, b  input  DATA_W each  operands.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-014 SHALL have port result  output  ACC_W  final sum, held until the next accepted start.
REQ-015 SHALL have port sat  output  1  sticky per job, accumulator clipped (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> ACC -> DRAIN -> DONE -> IDLE.
REQ-017 IDLE: start=1 with len>0 SHALL latch len and signed_mode, clear the accumulator, result and sat, and go to ACC.
REQ-018 IDLE: start=1 with len=0 SHALL go directly to DONE, giving result=0 and done one cycle later.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in ACC while fewer than len beats have been accepted.
REQ-021 Stage 1 SHALL register a*b, full 2*DATA_W bits, signed or unsigned per latched mode.
REQ-022 Stage 2 SHALL add the sign- or zero-extended product to the ACC_W accumulator.
REQ-023 After the len-th beat the FSM SHALL enter DRAIN and hold for 2 cycles until both pipeline stages are empty.
REQ-024 Latency: done SHALL assert exactly 3 cycles after the clock edge accepting the last beat.
REQ-025 DONE SHALL last 1 cycle, with done=1 and result updated in the same cycle, then return to IDLE.
REQ-026 Gaps in in_valid during ACC SHALL stall the job without limit and without corrupting it.
REQ-027 The beat counter SHALL be LEN_W bits wide; len = 2^LEN_W-1 SHALL complete correctly.

Reset
REQ-028 Reset SHALL force, at any time including mid-job: state=IDLE, in_ready=0, busy=0, done=0, result=0, sat=0, accumulator, pipeline registers and counter all 0.
REQ-029 The first start after reset deasserts SHALL be honoured on the first rising edge.

Configuration
REQ-030 With MAC_ACC_SAT_EN defined, accumulation overflow SHALL clamp to the max/min of ACC_W (signed or unsigned per mode) and set sat until the next start.
REQ-031 Without MAC_ACC_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W and sat SHALL be constant 0.

Structure
REQ-032 A shared package mac_pkg SHALL hold the FSM state enum, default widths and the pipeline depth constant (2).
REQ-033 The product stage SHALL be a sub-module mac_mul_stage: registered signed/unsigned DATA_W x DATA_W multiply with valid pass-through.

Verification
REQ-034 Unsigned: len=3, pairs (2,3),(4,5),(10,10) with no gaps -> result=126, done 3 cycles after the 3rd beat, sat=0.
REQ-035 Signed: len=2, pairs (-128,-128),(-1,127) -> result=16257.
REQ-036 len=0 start -> done on the next cycle with result=0; in_ready never asserts.
REQ-037 SAT_EN, ACC_W=16, signed: len=3, pairs (127,127),(127,127),(127,127) -> result=32767, sat=1; without the macro -> result=-17149 (0xBD03), sat=0.
REQ-038 Reset asserted after the 2nd of 4 beats -> all outputs 0 immediately; a fresh len=1 job (3,3) -> result=9.
REQ-039 in_valid toggling every other cycle plus a start pulse mid-job -> start ignored and result equals the gap-free reference sum.

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and defaults for the mac_acc dot-product engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int C_DATA_W     = 8;
    localparam int C_ACC_W      = 24;
    localparam int C_LEN_W      = 10;
    localparam int C_PIPE_DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mac_mul_stage
//  Description : Registered DATA_W x DATA_W multiply, signed or unsigned,
//                with a valid flag that travels alongside the product.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_mul_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  signed_mode,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   product
);

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic                r_valid;
    logic [2*DATA_W-1:0] r_prod;

    // Low 2*DATA_W bits of the extended product are exact in both modes.
    always_comb begin
        w_a_ext = {{DATA_W{signed_mode & a[DATA_W-1]}}, a};
        w_b_ext = {{DATA_W{signed_mode & b[DATA_W-1]}}, b};
        w_prod  = w_a_ext * w_b_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_prod  <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_prod <= w_prod;
            end
        end
    end

    assign out_valid = r_valid;
    assign product   = r_prod;

endmodule
`default_nettype wire

// File: rtl/mac_acc.sv
`default_nettype none
// ============================================================================
//  Module      : mac_acc
//  Description : Streaming multiply-accumulate dot-product engine with a
//                two-stage (multiply, accumulate) pipeline.
//                Define MAC_ACC_SAT_EN to clamp on overflow and report sat;
//                otherwise the accumulator wraps and sat is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_acc
    import mac_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ACC_W  = C_ACC_W,
    parameter int LEN_W  = C_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              signed_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              sat
);

    localparam logic [1:0] C_DRAIN_LAST = 2'(C_PIPE_DEPTH - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_count;
    logic                r_signed;
    logic [1:0]          r_drain;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_result;
    logic [ACC_W-1:0]    w_ext;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_start_ok;
    logic                w_beat;
    logic                w_finish;
    logic                w_mul_valid;
    logic [2*DATA_W-1:0] w_prod;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_beat     = in_valid && in_ready;
    assign w_finish   = (r_state == S_DRAIN) && (r_drain == C_DRAIN_LAST);

    // ------------------------------------------------------------------
    // Stage 1: product register
    // ------------------------------------------------------------------
    mac_mul_stage #(
        .DATA_W      (DATA_W)
    ) u_mul (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (w_beat),
        .signed_mode (r_signed),
        .a           (a),
        .b           (b),
        .out_valid   (w_mul_valid),
        .product     (w_prod)
    );

    generate
        if (ACC_W > 2*DATA_W) begin : g_ext_wide
            assign w_ext = {{(ACC_W-2*DATA_W){r_signed & w_prod[2*DATA_W-1]}}, w_prod};
        end else begin : g_ext_exact
            assign w_ext = w_prod;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: accumulate (saturating or wrapping)
    // ------------------------------------------------------------------
`ifdef MAC_ACC_SAT_EN
    logic [ACC_W:0] w_sum;
    logic           w_ovf;
    logic           r_sat;

    // One guard bit: in signed mode overflow shows as guard != MSB.
    always_comb begin
        w_sum      = {r_signed & r_acc[ACC_W-1], r_acc} + {r_signed & w_ext[ACC_W-1], w_ext};
        w_ovf      = r_signed ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            if (!r_signed) begin
                w_acc_next = '1;
            end else if (w_sum[ACC_W]) begin
                w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat <= 1'b0;
        end else if (w_start_ok) begin
            r_sat <= 1'b0;
        end else if (w_mul_valid && w_ovf) begin
            r_sat <= 1'b1;
        end
    end

    assign sat = r_sat;
`else
    always_comb begin
        w_acc_next = r_acc + w_ext;
    end

    assign sat = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len    <= '0;
            r_count  <= '0;
            r_signed <= 1'b0;
            r_drain  <= 2'd0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_start_ok) begin
                r_len    <= len;
                r_signed <= signed_mode;
                r_count  <= '0;
                r_acc    <= '0;
                r_result <= '0;
            end else begin
                if (w_beat) begin
                    r_count <= r_count + LEN_W'(1);
                end
                if (w_mul_valid) begin
                    r_acc <= w_acc_next;
                end
                if (w_finish) begin
                    r_result <= r_acc;
                end
            end
            r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ACC leaves one cycle after the final beat, so the two DRAIN cycles
    // complete exactly when the accumulator holds the last product.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (r_count == r_len) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == C_DRAIN_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_ACC) && (r_count != r_len);
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mac_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_acc
//  Description : Directed self-checking bench for mac_acc (DATA_W=8, ACC_W=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_acc;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic          signed_mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [AW-1:0] result;
    logic          sat;

    int n_cmp = 0;
    int n_err = 0;

    mac_acc #(
        .DATA_W      (DW),
        .ACC_W       (AW),
        .LEN_W       (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [LW-1:0] l, input logic sm);
        start = 1'b1; len = l; signed_mode = sm;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] va, input logic [DW-1:0] vb);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL beat_ready: in_ready=%b required 1 (waited %0d cycles)", in_ready, t);
        end else begin
            a = va; b = vb; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; len = '0; signed_mode = 1'b0;
        in_valid = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, in_ready, sat, result} !== {4'b0000, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b in_ready=%b sat=%b result=%h required all 0",
                     busy, done, in_ready, sat, result);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        int cyc;
        do_start(10'd3, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL unsigned_accept: busy=%b in_ready=%b required 1/1", busy, in_ready);
        end
        drive_beat(8'd2, 8'd3);
        drive_beat(8'd4, 8'd5);
        drive_beat(8'd10, 8'd10);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL unsigned_ready_drop: in_ready=%b required 0", in_ready);
        end
        wait_done(cyc);
        n_cmp++;
        if (cyc != 3 || done !== 1'b1) begin
            n_err++;
            $display("FAIL unsigned_latency: cycles=%0d done=%b required 3/1", cyc, done);
        end
        n_cmp++;
        if (result !== 16'd126 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL unsigned_result: result=%0d sat=%b required 126/0", result, sat);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 16'd126) begin
            n_err++;
            $display("FAIL unsigned_hold: done=%b busy=%b result=%0d required 0/0/126", done, busy, result);
        end
    endtask

    task automatic test_signed;
        int cyc;
        do_start(10'd2, 1'b1);
        drive_beat(8'h80, 8'h80);
        drive_beat(8'hFF, 8'h7F);
        wait_done(cyc);
        n_cmp++;
        if (done !== 1'b1 || result !== 16'd16257) begin
            n_err++;
            $display("FAIL signed_result: done=%b result=%0d required 1/16257", done, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed_neg;
        int cyc;
        do_start(10'd2, 1'b1);
        drive_beat(8'hFB, 8'd7);
        drive_beat(8'd3, 8'hFC);
        wait_done(cyc);
        n_cmp++;
        if (done !== 1'b1 || result !== 16'hFFD1 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL signed_negative: done=%b result=%h sat=%b required 1/ffd1/0", done, result, sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_zero;
        do_start(10'd0, 1'b0);
        n_cmp++;
        if (done !== 1'b1 || result !== 16'd0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL len0_done: done=%b result=%0d in_ready=%b required 1/0/0", done, result, in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL len0_idle: done=%b busy=%b in_ready=%b required 0/0/0", done, busy, in_ready);
        end
    endtask

    task automatic test_saturate;
        int cyc;
        logic [AW-1:0] exp_res;
        logic          exp_sat;
`ifdef MAC_ACC_SAT_EN
        exp_res = 16'h7FFF; exp_sat = 1'b1;
`else
        exp_res = 16'hBD03; exp_sat = 1'b0;
`endif
        do_start(10'd3, 1'b1);
        for (int i = 0; i < 3; i++) drive_beat(8'd127, 8'd127);
        wait_done(cyc);
        n_cmp++;
        if (done !== 1'b1 || result !== exp_res || sat !== exp_sat) begin
            n_err++;
            $display("FAIL saturate: done=%b result=%h sat=%b required 1/%h/%b", done, result, sat, exp_res, exp_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps_start_ignored;
        int cyc;
        logic [DW-1:0] va [4];
        logic [DW-1:0] vb [4];
        va = '{8'd10, 8'd30, 8'd50, 8'd70};
        vb = '{8'd20, 8'd40, 8'd60, 8'd80};
        do_start(10'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_beat(va[i], vb[i]);
            if (i == 1) begin
                start = 1'b1; len = 10'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 1) begin
                n_cmp++;
                if (busy !== 1'b1 || in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_start_ignored: busy=%b in_ready=%b required 1/1", busy, in_ready);
                end
            end
        end
        wait_done(cyc);
        n_cmp++;
        if (done !== 1'b1 || result !== 16'd10000) begin
            n_err++;
            $display("FAIL gap_result: done=%b result=%0d required 1/10000", done, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_len;
        int cyc;
        do_start(10'd1023, 1'b0);
        for (int i = 0; i < 1023; i++) drive_beat(8'd1, 8'd2);
        wait_done(cyc);
        n_cmp++;
        if (cyc != 3 || done !== 1'b1 || result !== 16'd2046) begin
            n_err++;
            $display("FAIL max_len: cycles=%0d done=%b result=%0d required 3/1/2046", cyc, done, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midjob;
        int cyc;
        do_start(10'd4, 1'b0);
        drive_beat(8'd5, 8'd5);
        drive_beat(8'd6, 8'd6);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, in_ready, sat, result} !== {4'b0000, 16'h0000}) begin
            n_err++;
            $display("FAIL midjob_reset: busy=%b done=%b in_ready=%b sat=%b result=%h required all 0",
                     busy, done, in_ready, sat, result);
        end
        @(negedge clk);
        reset = 1'b0;
        do_start(10'd1, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL first_start: busy=%b in_ready=%b required 1/1", busy, in_ready);
        end
        drive_beat(8'd3, 8'd3);
        wait_done(cyc);
        n_cmp++;
        if (cyc != 3 || done !== 1'b1 || result !== 16'd9) begin
            n_err++;
            $display("FAIL fresh_job: cycles=%0d done=%b result=%0d required 3/1/9", cyc, done, result);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (result !== 16'd0) begin
            n_err++;
            $display("FAIL idle_reset_result: result=%0d required 0", result);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_len_zero();
        test_saturate();
        test_signed_neg();
        test_gaps_start_ignored();
        test_max_len();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
